// File: rtl/puf_pkg.sv
// Shared types and constants for the RO-PUF response generator.
//   state_e      : measurement controller states
//   SEL_W/CHAL_W : oscillator select and challenge widths
//   DEF_*        : default parameter values for the top level
package puf_pkg;

  localparam int unsigned SEL_W  = 5;
  localparam int unsigned CHAL_W = 2 * SEL_W;

  localparam int unsigned DEF_CNT_W       = 16;
  localparam int unsigned DEF_WINDOW      = 1024;
  localparam int unsigned DEF_SETTLE_CYC  = 8;
  localparam int unsigned DEF_RESP_BITS   = 8;
  localparam int unsigned DEF_SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    COUNT   = 3'd2,
    COMPARE = 3'd3,
    DONE    = 3'd4
  } state_e;

endpackage

// File: rtl/puf_response_gen_ro_edge_counter.sv
// Synchronizes one asynchronous ring-oscillator output, detects its rising
// edges and counts them with a saturating counter.
// Ports:
//   clk, rst_n : clock and synchronous active-high reset
//   clr        : hold the counter and saturation flag at zero
//   en         : allow counting of detected edges
//   ro         : asynchronous oscillator output
//   cnt        : edge count, stops at all-ones
//   sat        : high while cnt is at its maximum
module ro_edge_counter #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             ro,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_dly;
  logic                   pulse;

  // Synchronizer runs continuously so edges in flight at window start count.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      sync_q   <= '0;
      sync_dly <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], ro};
      sync_dly <= sync_q[SYNC_STAGES-1];
    end
  end

  assign pulse = sync_q[SYNC_STAGES-1] & ~sync_dly;

  // Saturating counter; sat tracks cnt == CNT_MAX as a register.
  always_ff @(posedge clk) begin
    if (rst_n || clr) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (en && pulse && !sat) begin
      cnt <= cnt + CNT_W'(1);
      if (cnt == CNT_MAX - CNT_W'(1)) begin
        sat <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/puf_response_gen.sv
// RO-PUF measurement controller: steps through RESP_BITS oscillator pairs
// derived from a challenge, counts edges of both selected oscillators over a
// fixed window, and assembles the comparison bits into a response word
// offered with a valid/ack handshake.
// Ports:
//   clk, rst_n         : clock and synchronous active-high reset
//   start, challenge   : measurement request and base selects {B, A}
//   ro_a, ro_b         : asynchronous selected oscillator outputs
//   sel_a, sel_b       : oscillator selects to the upstream mux
//   ro_en              : oscillator enable
//   busy               : controller not idle
//   response           : assembled response word
//   resp_valid/ack     : response handshake
//   tie, sat           : sticky equal-count and counter-saturation flags
module puf_response_gen
  import puf_pkg::*;
#(
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned WINDOW      = DEF_WINDOW,
  parameter int unsigned SETTLE_CYC  = DEF_SETTLE_CYC,
  parameter int unsigned RESP_BITS   = DEF_RESP_BITS,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CHAL_W-1:0]    challenge,
  input  logic                 ro_a,
  input  logic                 ro_b,
  output logic [SEL_W-1:0]     sel_a,
  output logic [SEL_W-1:0]     sel_b,
  output logic                 ro_en,
  output logic                 busy,
  output logic [RESP_BITS-1:0] response,
  output logic                 resp_valid,
  input  logic                 resp_ack,
  output logic                 tie,
  output logic                 sat
);

  localparam int unsigned K_W     = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
  localparam int unsigned TMR_MAX = (WINDOW > SETTLE_CYC) ? WINDOW : SETTLE_CYC;
  localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0] WINDOW_LAST = TMR_W'(WINDOW - 1);
  localparam logic [K_W-1:0]   K_LAST      = K_W'(RESP_BITS - 1);

  state_e             state_q;
  state_e             state_d;
  logic [TMR_W-1:0]   tmr_q;
  logic [K_W-1:0]     k_q;
  logic [K_W-1:0]     k_nxt;
  logic [SEL_W-1:0]   base_a;
  logic [SEL_W-1:0]   base_b;
  logic               ro_en_d;
  logic               busy_d;
  logic               resp_valid_d;
  logic               cnt_clr;
  logic               cnt_en;
  logic [CNT_W-1:0]   cnt_a;
  logic [CNT_W-1:0]   cnt_b;
  logic               sat_a;
  logic               sat_b;

  assign k_nxt   = k_q + K_W'(1);
  assign cnt_clr = (state_q == SETTLE);
  assign cnt_en  = (state_q == COUNT);

  // Edge counters for the two selected oscillators, identical latency.
  ro_edge_counter #(
    .CNT_W       (CNT_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_cnt_a (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .ro    (ro_a),
    .cnt   (cnt_a),
    .sat   (sat_a)
  );

  ro_edge_counter #(
    .CNT_W       (CNT_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_cnt_b (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .ro    (ro_b),
    .cnt   (cnt_b),
    .sat   (sat_b)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SETTLE;
      SETTLE:  if (tmr_q == SETTLE_LAST) state_d = COUNT;
      COUNT:   if (tmr_q == WINDOW_LAST) state_d = COMPARE;
      COMPARE: state_d = (k_q == K_LAST) ? DONE : SETTLE;
      DONE:    if (resp_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the next state so the registered outputs line up
  // with the state they describe.
  always_comb begin
    ro_en_d      = 1'b0;
    busy_d       = 1'b0;
    resp_valid_d = 1'b0;
    case (state_d)
      SETTLE, COUNT: begin
        ro_en_d = 1'b1;
        busy_d  = 1'b1;
      end
      COMPARE: busy_d = 1'b1;
      DONE: begin
        busy_d       = 1'b1;
        resp_valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Phase timer, pair index, selects, response assembly and output registers.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      tmr_q      <= '0;
      k_q        <= '0;
      base_a     <= '0;
      base_b     <= '0;
      sel_a      <= '0;
      sel_b      <= '0;
      ro_en      <= 1'b0;
      busy       <= 1'b0;
      resp_valid <= 1'b0;
      response   <= '0;
      tie        <= 1'b0;
      sat        <= 1'b0;
    end else begin
      ro_en      <= ro_en_d;
      busy       <= busy_d;
      resp_valid <= resp_valid_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            base_a   <= challenge[SEL_W-1:0];
            base_b   <= challenge[CHAL_W-1:SEL_W];
            sel_a    <= challenge[SEL_W-1:0];
            sel_b    <= challenge[CHAL_W-1:SEL_W];
            k_q      <= '0;
            tmr_q    <= '0;
            response <= '0;
            tie      <= 1'b0;
            sat      <= 1'b0;
          end
        end
        SETTLE: tmr_q <= (tmr_q == SETTLE_LAST) ? '0 : tmr_q + TMR_W'(1);
        COUNT:  tmr_q <= (tmr_q == WINDOW_LAST) ? '0 : tmr_q + TMR_W'(1);
        COMPARE: begin
          response[k_q] <= (cnt_a > cnt_b);
          if (cnt_a == cnt_b) tie <= 1'b1;
          if (sat_a || sat_b) sat <= 1'b1;
          tmr_q <= '0;
          // Selects wrap mod 32 through the natural 5-bit add.
          if (k_q != K_LAST) begin
            k_q   <= k_nxt;
            sel_a <= base_a + SEL_W'(k_nxt);
            sel_b <= base_b + SEL_W'(k_nxt);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_puf_response_gen.sv
// Randomized self-checking bench for puf_response_gen. A behavioural model
// records the sampled oscillator waveforms, counts rising edges over each
// measurement window (shifted by the synchronizer latency) and predicts all
// outputs cycle by cycle.
module tb_puf_response_gen;

  localparam int S     = 4;
  localparam int W     = 64;
  localparam int RB    = 8;
  localparam int CW    = 5;
  localparam int NS    = 2;
  localparam int P     = S + W + 1;
  localparam int NTOT  = RB * P;
  localparam int CMAX  = (1 << CW) - 1;
  localparam int MAXC  = 65536;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [9:0] challenge;
  logic       ro_a = 1'b0;
  logic       ro_b = 1'b0;
  logic [4:0] sel_a;
  logic [4:0] sel_b;
  logic       ro_en;
  logic       busy;
  logic [7:0] response;
  logic       resp_valid;
  logic       resp_ack;
  logic       tie;
  logic       sat;

  puf_response_gen #(
    .CNT_W       (CW),
    .WINDOW      (W),
    .SETTLE_CYC  (S),
    .RESP_BITS   (RB),
    .SYNC_STAGES (NS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .challenge  (challenge),
    .ro_a       (ro_a),
    .ro_b       (ro_b),
    .sel_a      (sel_a),
    .sel_b      (sel_b),
    .ro_en      (ro_en),
    .busy       (busy),
    .response   (response),
    .resp_valid (resp_valid),
    .resp_ack   (resp_ack),
    .tie        (tie),
    .sat        (sat)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Oscillator waveform generator (changes away from the sampling edge).
  int pa = 4, pb = 6, ph_a = 0, ph_b = 0;
  bit same_wave = 1'b0;
  int gc = 0;
  always @(negedge clk) begin
    bit a;
    gc++;
    a = ((gc + ph_a) % pa) < (pa / 2);
    ro_a = a;
    ro_b = same_wave ? a : (((gc + ph_b) % pb) < (pb / 2));
  end

  // Behavioural model.
  bit        hist_a [0:MAXC-1];
  bit        hist_b [0:MAXC-1];
  bit        m_active = 1'b0, m_done = 1'b0;
  int        m_t = 0;
  logic [4:0] m_base_a = '0, m_base_b = '0, m_sel_a = '0, m_sel_b = '0;
  logic [7:0] m_resp = '0;
  bit        m_tie = 1'b0, m_sat = 1'b0, m_busy = 1'b0, m_ro_en = 1'b0;

  function automatic int count_edges(input bit use_b, input int tk);
    int c = 0;
    for (int j = tk + S + 1 - NS; j <= tk + S + W - NS; j++) begin
      if (j >= 1 && j < MAXC) begin
        if (use_b) begin
          if (hist_b[j] && !hist_b[j-1]) c++;
        end else begin
          if (hist_a[j] && !hist_a[j-1]) c++;
        end
      end
    end
    return c;
  endfunction

  always @(posedge clk) begin
    int d, k, ca, cb;
    cyc++;
    if (cyc < MAXC) begin
      hist_a[cyc] = ro_a;
      hist_b[cyc] = ro_b;
    end
    if (rst_n) begin
      m_active = 1'b0; m_done = 1'b0;
      m_resp = '0; m_tie = 1'b0; m_sat = 1'b0;
      m_sel_a = '0; m_sel_b = '0;
    end else if (m_done) begin
      if (resp_ack) m_done = 1'b0;
    end else if (m_active) begin
      d = cyc - m_t;
      if (d % P == 0) begin
        k  = d / P - 1;
        ca = count_edges(1'b0, m_t + k * P);
        cb = count_edges(1'b1, m_t + k * P);
        if (ca >= CMAX) begin ca = CMAX; m_sat = 1'b1; end
        if (cb >= CMAX) begin cb = CMAX; m_sat = 1'b1; end
        m_resp[k] = (ca > cb);
        if (ca == cb) m_tie = 1'b1;
        if (k == RB - 1) begin
          m_active = 1'b0;
          m_done   = 1'b1;
        end else begin
          m_sel_a = 5'((int'(m_base_a) + k + 1) % 32);
          m_sel_b = 5'((int'(m_base_b) + k + 1) % 32);
        end
      end
    end else if (start) begin
      m_t = cyc;
      m_base_a = challenge[4:0];
      m_base_b = challenge[9:5];
      m_sel_a = challenge[4:0];
      m_sel_b = challenge[9:5];
      m_resp = '0; m_tie = 1'b0; m_sat = 1'b0;
      m_active = 1'b1;
    end
    m_busy  = m_active || m_done;
    m_ro_en = m_active && (((cyc - m_t) % P) < (S + W));
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, m_busy);
      chk("ro_en", ro_en, m_ro_en);
      chk("resp_valid", resp_valid, m_done);
      chk("sel_a", sel_a, m_sel_a);
      chk("sel_b", sel_b, m_sel_b);
      chk("response", response, m_resp);
      chk("tie", tie, m_tie);
      if (!m_active) chk("sat", sat, m_sat);
    end
  end

  int t0 = 0;

  task automatic start_run(input logic [9:0] ch);
    @(negedge clk);
    challenge = ch;
    start = 1'b1;
    t0 = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic finish_run(input int dly, input bit noisy, input bit ack_start, output int lat);
    bit got = 1'b0;
    lat = -1;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        got = 1'b1;
        lat = cyc - t0;
        start = 1'b0;
        resp_ack = 1'b0;
      end else if (noisy) begin
        start    = ($urandom_range(0, 7) == 0);
        resp_ack = ($urandom_range(0, 7) == 0);
      end
    end
    if (!got) begin
      start = 1'b0;
      resp_ack = 1'b0;
      chk("resp_valid_timeout", 0, 1);
    end else begin
      repeat (dly) @(negedge clk);
      resp_ack = 1'b1;
      start = ack_start;
      @(negedge clk);
      resp_ack = 1'b0;
      start = 1'b0;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst_n = 1'b1; start = 1'b0; challenge = '0; resp_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", resp_valid, 0);
    chk("rst_resp", response, 0);
    chk("rst_sel_a", sel_a, 0);
    chk("rst_ro_en", ro_en, 0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    // A faster than B.
    pa = 4; pb = 6; same_wave = 1'b0;
    start_run(10'h000);
    finish_run(2, 1'b0, 1'b0, lat);
    chk("r1_latency", lat, 552);
    chk("r1_resp", response, 8'hFF);
    chk("r1_tie", tie, 0);
    chk("r1_sat", sat, 0);

    // B faster than A.
    pa = 6; pb = 4;
    start_run(10'h155);
    finish_run(0, 1'b0, 1'b0, lat);
    chk("r2_resp", response, 8'h00);
    chk("r2_tie", tie, 0);

    // Identical waveforms.
    pa = 5; same_wave = 1'b1;
    start_run(10'h2A3);
    finish_run(1, 1'b0, 1'b0, lat);
    chk("r3_resp", response, 8'h00);
    chk("r3_tie", tie, 1);
    same_wave = 1'b0;

    // Select stepping with 5-bit wrap.
    pa = 4; pb = 6;
    start_run({5'd3, 5'd30});
    while (cyc < t0 + 5) @(negedge clk);
    chk("r4_sel_a_k0", sel_a, 30);
    chk("r4_sel_b_k0", sel_b, 3);
    while (cyc < t0 + 2 * P + 5) @(negedge clk);
    chk("r4_sel_a_k2", sel_a, 0);
    chk("r4_sel_b_k2", sel_b, 5);
    while (cyc < t0 + 7 * P + 5) @(negedge clk);
    chk("r4_sel_a_k7", sel_a, 5);
    chk("r4_sel_b_k7", sel_b, 10);
    finish_run(0, 1'b0, 1'b0, lat);

    // Saturation: 32 edges per window against a 5-bit counter.
    pa = 2; pb = 3;
    start_run(10'h0F0);
    finish_run(0, 1'b1, 1'b0, lat);
    chk("r5_sat", sat, 1);
    chk("r5_resp", response, 8'hFF);

    // Hold valid 10 cycles, start+ack together in DONE is not a new start.
    pa = 7; pb = 3;
    start_run(10'h3FF);
    finish_run(10, 1'b1, 1'b1, lat);
    chk("ack_busy", busy, 0);
    chk("ack_valid", resp_valid, 0);

    // Reset in the middle of COUNT.
    start_run(10'h123);
    repeat (S + 20) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    chk("mrst_busy", busy, 0);
    chk("mrst_ro_en", ro_en, 0);
    chk("mrst_sel_a", sel_a, 0);
    chk("mrst_sel_b", sel_b, 0);
    chk("mrst_resp", response, 0);
    chk("mrst_valid", resp_valid, 0);
    chk("mrst_tie", tie, 0);
    chk("mrst_sat", sat, 0);
    repeat (2) @(negedge clk);
    pa = 4; pb = 6;
    start_run(10'h000);
    finish_run(0, 1'b0, 1'b0, lat);
    chk("post_rst_latency", lat, NTOT);
    chk("post_rst_resp", response, 8'hFF);

    // Randomized runs.
    for (int r = 0; r < 10; r++) begin
      pa = $urandom_range(2, 12);
      pb = $urandom_range(2, 12);
      ph_a = $urandom_range(0, 11);
      ph_b = $urandom_range(0, 11);
      same_wave = ($urandom_range(0, 4) == 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      start_run(10'($urandom));
      finish_run($urandom_range(0, 5), 1'b1, 1'($urandom_range(0, 1)), lat);
      chk("rand_latency", lat, NTOT);
    end

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
